// File: rtl/spi_serf.sv
// Subordinate end of the 16-bit full-duplex SPI link (CPOL=1, CPHA=1).
// Captures a command frame from the monarch and returns a buffered response on MISO.
module spi_serf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output wire         MISO,
  input  logic        wrt,
  input  logic [15:0] tx_data,
  output logic [15:0] cmd,
  output logic        rdy,
  input  logic        clr_rdy,
  output logic        err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_nxt_state;

  logic        r_ss_ff1, r_ss_ff2, r_ss_ff3;
  logic        r_sclk_ff1, r_sclk_ff2, r_sclk_ff3;
  logic        r_mosi_ff1, r_mosi_ff2;

  logic [15:0] r_tx_buf;
  logic [15:0] r_shft_reg;
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_cmd;
  logic        r_rdy;
  logic        r_err;

  logic        w_sclk_rise;
  logic        w_ss_fall;
  logic        w_ss_rise;
  logic        w_load;
  logic        w_shift;
  logic        w_set_rdy;
  logic        w_err;

  // Synchronizers for the pad inputs; the third SCLK/SS_n flop is only for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_ff1   <= 1'b1;
      r_ss_ff2   <= 1'b1;
      r_ss_ff3   <= 1'b1;
      r_sclk_ff1 <= 1'b1;
      r_sclk_ff2 <= 1'b1;
      r_sclk_ff3 <= 1'b1;
      r_mosi_ff1 <= 1'b1;
      r_mosi_ff2 <= 1'b1;
    end else begin
      r_ss_ff1   <= SS_n;
      r_ss_ff2   <= r_ss_ff1;
      r_ss_ff3   <= r_ss_ff2;
      r_sclk_ff1 <= SCLK;
      r_sclk_ff2 <= r_sclk_ff1;
      r_sclk_ff3 <= r_sclk_ff2;
      r_mosi_ff1 <= MOSI;
      r_mosi_ff2 <= r_mosi_ff1;
    end
  end

  assign w_sclk_rise = r_sclk_ff2 & ~r_sclk_ff3;
  assign w_ss_fall   = ~r_ss_ff2 & r_ss_ff3;
  assign w_ss_rise   = r_ss_ff2 & ~r_ss_ff3;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    w_nxt_state = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_set_rdy   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_load      = 1'b1;
          w_nxt_state = ACTIVE;
        end else begin
          w_nxt_state = IDLE;
        end
      end
      ACTIVE: begin
        w_shift = w_sclk_rise;
        if (w_ss_rise) begin
          w_nxt_state = IDLE;
          if (r_bit_cnt == 5'd16) begin
            w_set_rdy = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end else begin
          w_nxt_state = ACTIVE;
        end
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  // Transmit buffer persists across frames until the next wrt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_buf <= 16'h0000;
    end else if (wrt) begin
      r_tx_buf <= tx_data;
    end
  end

  // Shift register and bit counter; wrt coincident with frame start bypasses the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shft_reg <= 16'h0000;
      r_bit_cnt  <= 5'd0;
    end else if (w_load) begin
      r_shft_reg <= wrt ? tx_data : r_tx_buf;
      r_bit_cnt  <= 5'd0;
    end else if (w_shift) begin
      r_shft_reg <= {r_shft_reg[14:0], r_mosi_ff2};
      if (r_bit_cnt != 5'd31) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
    end
  end

  // Frame completion: command capture, ready flag and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= 16'h0000;
      r_rdy <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_set_rdy) begin
        r_cmd <= r_shft_reg;
      end
      if (w_set_rdy) begin
        r_rdy <= 1'b1;
      end else if (w_load || clr_rdy) begin
        r_rdy <= 1'b0;
      end
    end
  end

  assign cmd  = r_cmd;
  assign rdy  = r_rdy;
  assign err  = r_err;
  // Raw pad select gates the driver so MISO releases without synchronizer delay
  assign MISO = SS_n ? 1'bz : r_shft_reg[15];

endmodule
